// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
//
// Purpose : MD unit state encodings, the "operand unused" Tuse code,
//           MD operation type codes and the per-source hazard compare.
// Ports   : none (package)
package pipe_hazard_ctrl_pkg;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  // Tuse code meaning the instruction does not read that operand
  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic MD_TYPE_MULT = 1'b0;
  localparam logic MD_TYPE_DIV  = 1'b1;

  // A source conflicts with a producer when it names the same nonzero
  // register and is needed before the producer's result is available.
  function automatic logic src_hazard(input logic [4:0] src,
                                      input logic [1:0] tuse,
                                      input logic [4:0] wreg,
                                      input logic [1:0] tnew);
    return (src != 5'd0) && (tuse != TUSE_NONE) && (src == wreg) && (tuse < tnew);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - pipeline-to-hazard-controller signal bundle
//
// Purpose : groups the ID/EX/MEM hazard inputs and the stall outputs.
// Modports: master - pipeline side (drives stage info, receives stall controls)
//           slave  - hazard controller side
interface pipe_hazard_ctrl_if;
  logic [4:0]  ID_Rs;
  logic [4:0]  ID_Rt;
  logic [1:0]  ID_TuseRs;
  logic [1:0]  ID_TuseRt;
  logic        ID_IsMD;
  logic [4:0]  EX_WReg;
  logic [4:0]  MEM_WReg;
  logic [1:0]  EX_Tnew;
  logic [1:0]  MEM_Tnew;
  logic        EX_MDStart;
  logic        EX_MDType;
  logic        Cnt_Clr;
  logic        Stall;
  logic        PC_En;
  logic        ID_EX_Flush;
  logic        MD_Busy;
  logic [15:0] Stall_Cnt;

  modport master (
    output ID_Rs, ID_Rt, ID_TuseRs, ID_TuseRt, ID_IsMD,
    output EX_WReg, MEM_WReg, EX_Tnew, MEM_Tnew, EX_MDStart, EX_MDType, Cnt_Clr,
    input  Stall, PC_En, ID_EX_Flush, MD_Busy, Stall_Cnt
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_TuseRs, ID_TuseRt, ID_IsMD,
    input  EX_WReg, MEM_WReg, EX_Tnew, MEM_Tnew, EX_MDStart, EX_MDType, Cnt_Clr,
    output Stall, PC_En, ID_EX_Flush, MD_Busy, Stall_Cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_md_busy_fsm.sv
// rtl/pipe_hazard_ctrl_md_busy_fsm.sv - mult/div unit busy tracker
//
// Purpose : IDLE/RUN FSM with a 4-bit down-counter of remaining busy cycles.
// Ports   : clk, rst        - clock, async active-high reset
//           md_start_i      - EX starts a mult/div this cycle
//           md_type_i       - 0 mult/multu, 1 div/divu
//           md_busy_o       - MD unit busy, including the start cycle
module md_busy_fsm
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic md_start_i,
  input  logic md_type_i,
  output logic md_busy_o
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  md_state_e  state_q;
  logic [3:0] md_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MD_IDLE;
      md_cnt_q <= 4'd0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (md_start_i) begin
            state_q  <= MD_RUN;
            md_cnt_q <= (md_type_i == MD_TYPE_DIV) ? DIV_LOAD : MULT_LOAD;
          end
        end
        MD_RUN: begin
          // a new start while running is ignored; the count runs out untouched
          md_cnt_q <= md_cnt_q - 4'd1;
          if (md_cnt_q == 4'd1) begin
            state_q <= MD_IDLE;
          end
        end
        default: begin
          state_q  <= MD_IDLE;
          md_cnt_q <= 4'd0;
        end
      endcase
    end
  end

  // busy covers the start cycle itself, so it must see md_start_i directly
  assign md_busy_o = !rst && ((state_q == MD_RUN) || md_start_i);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall generation and stall counter
//
// Purpose : combinational data/MD stall decision plus saturating stall counter.
// Ports   : clk, reset - clock, async active-high reset
//           bus        - pipe_hazard_ctrl_if.slave (stage info in, stall controls out)
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  pipe_hazard_ctrl_if.slave    bus
);

  logic        md_busy;
  logic        data_stall;
  logic        md_stall;
  logic        stall;
  logic [15:0] stall_cnt_q;
  logic [15:0] stall_cnt_d;

  md_busy_fsm #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy_fsm (
    .clk        (clk),
    .rst        (reset),
    .md_start_i (bus.EX_MDStart),
    .md_type_i  (bus.EX_MDType),
    .md_busy_o  (md_busy)
  );

  assign data_stall = src_hazard(bus.ID_Rs, bus.ID_TuseRs, bus.EX_WReg,  bus.EX_Tnew)
                   || src_hazard(bus.ID_Rs, bus.ID_TuseRs, bus.MEM_WReg, bus.MEM_Tnew)
                   || src_hazard(bus.ID_Rt, bus.ID_TuseRt, bus.EX_WReg,  bus.EX_Tnew)
                   || src_hazard(bus.ID_Rt, bus.ID_TuseRt, bus.MEM_WReg, bus.MEM_Tnew);

  assign md_stall = bus.ID_IsMD && md_busy;

  // reset masks every stall source so the pipeline free-runs while held
  assign stall = !reset && (data_stall || md_stall);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.Cnt_Clr) begin
      stall_cnt_d = 16'd0;
    end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.Stall       = stall;
  assign bus.PC_En       = !stall;
  assign bus.ID_EX_Flush = stall;
  assign bus.MD_Busy     = md_busy;
  assign bus.Stall_Cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam int O_STALL = 0;
  localparam int O_PCEN  = 1;
  localparam int O_FLUSH = 2;
  localparam int O_BUSY  = 3;
  localparam int O_CNT   = 4;

  typedef struct {
    string       tag;
    int          sel;
    logic [15:0] exp;
  } sb_entry_t;

  logic clk;
  logic reset;
  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  sb_entry_t   sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_cnt  = 16'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] observe(input int sel);
    case (sel)
      O_STALL: return {15'd0, bus.Stall};
      O_PCEN:  return {15'd0, bus.PC_En};
      O_FLUSH: return {15'd0, bus.ID_EX_Flush};
      O_BUSY:  return {15'd0, bus.MD_Busy};
      default: return bus.Stall_Cnt;
    endcase
  endfunction

  task automatic push(input string tag, input logic exp_stall, input logic exp_busy);
    sb.push_back('{{tag, ".stall"}, O_STALL, {15'd0, exp_stall}});
    sb.push_back('{{tag, ".pc_en"}, O_PCEN,  {15'd0, !exp_stall}});
    sb.push_back('{{tag, ".flush"}, O_FLUSH, {15'd0, exp_stall}});
    sb.push_back('{{tag, ".busy"},  O_BUSY,  {15'd0, exp_busy}});
    sb.push_back('{{tag, ".cnt"},   O_CNT,   exp_cnt});
  endtask

  task automatic drain();
    sb_entry_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.sel), e.exp);
    end
  endtask

  // one clock cycle: queue expectations for current inputs, compare mid-cycle,
  // then advance the reference stall counter across the rising edge
  task automatic step(input string tag, input logic exp_stall, input logic exp_busy);
    push(tag, exp_stall, exp_busy);
    @(negedge clk);
    drain();
    @(posedge clk);
    if (reset || bus.Cnt_Clr) exp_cnt = 16'd0;
    else if (exp_stall && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    #1;
  endtask

  task automatic idle_inputs();
    bus.ID_Rs = 5'd0;  bus.ID_Rt = 5'd0;
    bus.ID_TuseRs = 2'd3; bus.ID_TuseRt = 2'd3;
    bus.ID_IsMD = 1'b0;
    bus.EX_WReg = 5'd0; bus.MEM_WReg = 5'd0;
    bus.EX_Tnew = 2'd0; bus.MEM_Tnew = 2'd0;
    bus.EX_MDStart = 1'b0; bus.EX_MDType = 1'b0;
    bus.Cnt_Clr = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    // hazard and MD start presented while in reset: outputs must stay quiet
    bus.ID_Rs = 5'd8; bus.ID_TuseRs = 2'd0; bus.EX_WReg = 5'd8; bus.EX_Tnew = 2'd2;
    bus.ID_IsMD = 1'b1; bus.EX_MDStart = 1'b1;
    step("rst_hold", 1'b0, 1'b0);
    reset = 1'b0;
    idle_inputs();
    step("idle", 1'b0, 1'b0);

    // Rs vs EX producer
    bus.ID_Rs = 5'd8; bus.ID_TuseRs = 2'd0; bus.EX_WReg = 5'd8; bus.EX_Tnew = 2'd1;
    step("rs_ex", 1'b1, 1'b0);
    bus.EX_WReg = 5'd0;
    step("rs_ex_w0", 1'b0, 1'b0);
    // register 0 never stalls
    bus.ID_Rs = 5'd0; bus.EX_WReg = 5'd0; bus.EX_Tnew = 2'd3;
    step("r0", 1'b0, 1'b0);
    // Rt vs MEM: equal Tuse/Tnew is no stall, smaller Tuse stalls
    idle_inputs();
    bus.ID_Rt = 5'd5; bus.ID_TuseRt = 2'd1; bus.MEM_WReg = 5'd5; bus.MEM_Tnew = 2'd1;
    step("rt_mem_eq", 1'b0, 1'b0);
    bus.ID_TuseRt = 2'd0;
    step("rt_mem_lt", 1'b1, 1'b0);
    // unused operand never stalls
    bus.ID_TuseRt = 2'd3; bus.MEM_Tnew = 2'd3;
    step("rt_unused", 1'b0, 1'b0);
    // Rs vs MEM and Rt vs EX
    idle_inputs();
    bus.ID_Rs = 5'd17; bus.ID_TuseRs = 2'd1; bus.MEM_WReg = 5'd17; bus.MEM_Tnew = 2'd2;
    step("rs_mem", 1'b1, 1'b0);
    idle_inputs();
    bus.ID_Rt = 5'd31; bus.ID_TuseRt = 2'd2; bus.EX_WReg = 5'd31; bus.EX_Tnew = 2'd3;
    step("rt_ex", 1'b1, 1'b0);

    // div with ID_IsMD held: busy and stall t..t+10, clear at t+11
    idle_inputs();
    bus.ID_IsMD = 1'b1;
    bus.EX_MDStart = 1'b1; bus.EX_MDType = 1'b1;
    step("div_t0", 1'b1, 1'b1);
    bus.EX_MDStart = 1'b0;
    for (int i = 1; i <= 10; i++) step($sformatf("div_t%0d", i), 1'b1, 1'b1);
    step("div_t11", 1'b0, 1'b0);

    // mult with a second start at t+2 that must not reload the counter
    bus.ID_IsMD = 1'b0;
    bus.EX_MDStart = 1'b1; bus.EX_MDType = 1'b0;
    step("mul_t0", 1'b0, 1'b1);
    bus.EX_MDStart = 1'b0;
    step("mul_t1", 1'b0, 1'b1);
    bus.EX_MDStart = 1'b1; bus.EX_MDType = 1'b1;
    step("mul_t2", 1'b0, 1'b1);
    bus.EX_MDStart = 1'b0;
    for (int i = 3; i <= 5; i++) step($sformatf("mul_t%0d", i), 1'b0, 1'b1);
    step("mul_t6", 1'b0, 1'b0);

    // reset pulse mid-RUN, between clock edges
    bus.EX_MDStart = 1'b1; bus.EX_MDType = 1'b0;
    step("ab_t0", 1'b0, 1'b1);
    bus.EX_MDStart = 1'b0;
    step("ab_t1", 1'b0, 1'b1);
    bus.ID_IsMD = 1'b1;
    step("ab_t2", 1'b1, 1'b1);
    reset = 1'b1;
    #1;
    exp_cnt = 16'd0;
    push("ab_rst", 1'b0, 1'b0);
    drain();
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step($sformatf("ab_post%0d", i), 1'b0, 1'b0);

    // saturation: clear, ramp the counter to FFFE, then observe the ceiling
    bus.ID_IsMD = 1'b0;
    bus.ID_Rs = 5'd9; bus.ID_TuseRs = 2'd0; bus.EX_WReg = 5'd9; bus.EX_Tnew = 2'd1;
    bus.Cnt_Clr = 1'b1;
    step("sat_clr", 1'b1, 1'b0);
    bus.Cnt_Clr = 1'b0;
    repeat (65534) @(posedge clk);
    #1;
    exp_cnt = 16'hFFFE;
    for (int i = 0; i < 3; i++) step($sformatf("sat%0d", i), 1'b1, 1'b0);
    step("sat_hold", 1'b1, 1'b0);
    bus.Cnt_Clr = 1'b1;
    step("clr_prio", 1'b1, 1'b0);
    idle_inputs();
    step("clr_done", 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
